// File: rtl/tlul_pkg.sv
// Minimal TL-UL channel structs shared by hosts, crossbar and devices.
package tlul_pkg;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [1:0]  a_size;
    logic [3:0]  a_source;
    logic [31:0] a_address;
    logic [31:0] a_data;
    logic [3:0]  a_mask;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [3:0]  d_source;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/xbar_pkg.sv
// Crossbar host enumeration and shared sizing constants.
package xbar_pkg;

  localparam int N_HOST             = 2;
  localparam int XbarMaxOutstanding = 4;

  typedef enum logic {
    TlBrqif  = 1'b0,
    TlBrqlsu = 1'b1
  } tl_host_e;

  typedef logic tl_host_idx_t;

endpackage

// File: rtl/xbar_id_fifo.sv
// Small synchronous FIFO carrying host indices of in-flight requests.
module xbar_id_fifo #(
  parameter int Width = 1,
  parameter int Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth) + 1;

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem[rptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/xbar_dev_arbiter.sv
// Two-host round-robin arbiter onto one TL-UL device port with in-order
// response routing via a FIFO of granted host indices.
module xbar_dev_arbiter
  import tlul_pkg::*;
  import xbar_pkg::*;
#(
  parameter int MaxOutstanding = XbarMaxOutstanding,
  parameter int NHost          = N_HOST
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  tl_h2d_t                           tl_h_i [NHost],
  output tl_d2h_t                           tl_h_o [NHost],
  output tl_h2d_t                           tl_d_o,
  input  tl_d2h_t                           tl_d_i,
  output logic [$clog2(MaxOutstanding):0]   outstanding_o,
  output logic                              err_unexp_o
);

  tl_host_idx_t prio_q, held_host_q, gnt, head;
  logic         held_q, fifo_full, fifo_empty;
  logic         gnt_valid, a_hs, d_pop, head_d_ready;

  always_comb begin
    if (held_q)                                                gnt = held_host_q;
    else if (tl_h_i[TlBrqif].a_valid && tl_h_i[TlBrqlsu].a_valid) gnt = prio_q;
    else if (tl_h_i[TlBrqlsu].a_valid)                         gnt = TlBrqlsu;
    else                                                       gnt = TlBrqif;
  end

  assign gnt_valid    = tl_h_i[gnt].a_valid & ~fifo_full;
  assign a_hs         = gnt_valid & tl_d_i.a_ready;
  // With nothing outstanding the device beat is dropped rather than stalled.
  assign head_d_ready = fifo_empty | tl_h_i[head].d_ready;
  assign d_pop        = tl_d_i.d_valid & head_d_ready & ~fifo_empty;

  always_comb begin
    tl_d_o         = tl_h_i[gnt];
    tl_d_o.a_valid = gnt_valid;
    tl_d_o.d_ready = head_d_ready;
  end

  always_comb begin
    for (int h = 0; h < NHost; h++) begin
      tl_h_o[h]         = tl_d_i;
      tl_h_o[h].a_ready = a_hs & (gnt == tl_host_idx_t'(h));
      tl_h_o[h].d_valid = tl_d_i.d_valid & ~fifo_empty & (head == tl_host_idx_t'(h));
    end
  end

  // Grant locks once offered to the device so the A payload stays stable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q      <= TlBrqif;
      held_q      <= 1'b0;
      held_host_q <= TlBrqif;
      err_unexp_o <= 1'b0;
    end else begin
      err_unexp_o <= tl_d_i.d_valid & fifo_empty;
      if (a_hs) begin
        prio_q <= ~gnt;
        held_q <= 1'b0;
      end else if (gnt_valid) begin
        held_q      <= 1'b1;
        held_host_q <= gnt;
      end
    end
  end

  xbar_id_fifo #(
    .Width (1),
    .Depth (MaxOutstanding)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (a_hs),
    .wdata_i (gnt),
    .pop_i   (d_pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding_o)
  );

endmodule

// File: tb/tb_xbar_dev_arbiter.sv
// Directed corner cases plus randomized traffic against a transaction-level model.
module tb_xbar_dev_arbiter;
  import tlul_pkg::*;
  import xbar_pkg::*;

  localparam int MAXO = 4;

  logic    clk_i = 1'b0;
  logic    rst_ni = 1'b0;
  tl_h2d_t h_i [2];
  tl_d2h_t h_o [2];
  tl_h2d_t d_o;
  tl_d2h_t d_i;
  logic [2:0] outst;
  logic       err;

  xbar_dev_arbiter #(.MaxOutstanding(MAXO), .NHost(2)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .tl_h_i        (h_i),
    .tl_h_o        (h_o),
    .tl_d_o        (d_o),
    .tl_d_i        (d_i),
    .outstanding_o (outst),
    .err_unexp_o   (err)
  );

  always #5 clk_i = ~clk_i;

  int total = 0, bad = 0;

  // stimulus state
  bit          hv [2];
  logic [31:0] haddr [2];
  bit          hdr [2];
  bit          dev_ar, dev_dv;
  logic [31:0] dev_data;
  int          cnt = 0;

  // reference model: queue of hosts owed a response, plus arbitration rules
  int m_q [$];
  int m_prio, m_hh, last_g;
  bit m_held, m_err, last_hs;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic apply();
    for (int h = 0; h < 2; h++) begin
      h_i[h]           = '0;
      h_i[h].a_valid   = hv[h];
      h_i[h].a_address = haddr[h];
      h_i[h].a_data    = ~haddr[h];
      h_i[h].a_source  = 4'(h);
      h_i[h].d_ready   = hdr[h];
    end
    d_i          = '0;
    d_i.a_ready  = dev_ar;
    d_i.d_valid  = dev_dv;
    d_i.d_data   = dev_data;
    d_i.d_source = 4'h5;
  endtask

  task automatic issue(input int h);
    hv[h]    = 1'b1;
    haddr[h] = {(h == 0) ? 4'h1 : 4'h2, 28'(cnt)};
    cnt++;
  endtask

  // Check one cycle against the model, then advance model and clock.
  task automatic tick();
    int g, head;
    bit avo, hs, pop;
    apply();
    #1;
    if (m_held)            g = m_hh;
    else if (hv[0] && hv[1]) g = m_prio;
    else                   g = hv[1] ? 1 : 0;
    avo = hv[g] && (m_q.size() < MAXO);
    hs  = avo && dev_ar;
    chk("a_valid", d_o.a_valid, avo);
    if (avo) chk("a_addr", d_o.a_address, haddr[g]);
    for (int h = 0; h < 2; h++) chk("a_ready", h_o[h].a_ready, hs && (h == g));
    chk("outstanding", outst, m_q.size());
    chk("err_unexp", err, m_err);
    pop = 1'b0;
    if (m_q.size() == 0) begin
      chk("d_ready_drop", d_o.d_ready, 1);
      for (int h = 0; h < 2; h++) chk("d_valid_empty", h_o[h].d_valid, 0);
    end else begin
      head = m_q[0];
      chk("d_ready", d_o.d_ready, hdr[head]);
      for (int h = 0; h < 2; h++) chk("d_valid", h_o[h].d_valid, dev_dv && (h == head));
      if (dev_dv) chk("d_data", h_o[head].d_data, dev_data);
      pop = dev_dv && hdr[head];
    end
    last_g  = g;
    last_hs = hs;
    m_err = dev_dv && (m_q.size() == 0);
    if (pop) void'(m_q.pop_front());
    if (hs) begin
      m_q.push_back(g);
      m_prio = 1 - g;
      m_held = 1'b0;
    end else if (avo) begin
      m_held = 1'b1;
      m_hh   = g;
    end
    @(negedge clk_i);
    if (last_hs) hv[last_g] = 1'b0;
  endtask

  task automatic peek_grant(input string tag, input logic [3:0] exp);
    apply();
    #1;
    chk(tag, d_o.a_address[31:28], exp);
  endtask

  task automatic reset_dut();
    hv[0] = 0; hv[1] = 0; dev_dv = 0; dev_ar = 0;
    apply();
    rst_ni = 1'b0;
    #1;
    chk("rst_outstanding", outst, 0);
    chk("rst_err", err, 0);
    m_q.delete();
    m_prio = 0; m_held = 0; m_hh = 0; m_err = 0; last_hs = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    hv[0] = 0; hv[1] = 0; hdr[0] = 1; hdr[1] = 1; dev_dv = 1;
    while (m_q.size() > 0 && n < 50) begin
      dev_data = $urandom;
      tick();
      n++;
    end
    if (m_q.size() > 0) chk("drain_timeout", 1, 0);
    dev_dv = 0;
  endtask

  initial begin
    hdr[0] = 1; hdr[1] = 1; dev_data = '0;
    @(negedge clk_i);
    reset_dut();
    tick();  // idle after reset: nothing valid, nothing ready

    // round-robin alternation, both hosts always valid
    dev_ar = 1; issue(0); issue(1);
    for (int i = 0; i < 4; i++) begin
      peek_grant("rr_seq", (i % 2) ? 4'h2 : 4'h1);
      tick();
      if (!hv[0]) issue(0);
      if (!hv[1] && i < 3) issue(1);
    end
    // FIFO full: 5th request stalls until a response frees a slot
    apply(); #1;
    chk("full_outst", outst, 4);
    chk("full_ardy", h_o[0].a_ready, 0);
    tick();
    dev_dv = 1; dev_data = 32'h55;
    tick();
    dev_dv = 0;
    apply(); #1;
    chk("acc5_ardy", h_o[0].a_ready, 1);
    tick();
    drain();

    // grant hold while device stalls
    reset_dut();
    issue(1);
    tick();
    issue(0);
    for (int i = 0; i < 3; i++) begin
      peek_grant("hold_lsu", 4'h2);
      tick();
    end
    dev_ar = 1;
    peek_grant("hold_hs", 4'h2);
    chk("hold_hs_ardy", h_o[1].a_ready, 1);
    tick();
    peek_grant("after_hold", 4'h1);
    tick();
    drain();

    // in-order response routing IF,LSU,IF
    reset_dut();
    dev_ar = 1;
    issue(0); tick();
    issue(1); tick();
    issue(0); tick();
    dev_dv = 1;
    dev_data = 32'hA; apply(); #1;
    chk("rsp_a_if", h_o[0].d_valid, 1); chk("rsp_a_lsu", h_o[1].d_valid, 0);
    chk("rsp_a_data", h_o[0].d_data, 32'hA);
    tick();
    dev_data = 32'hB; apply(); #1;
    chk("rsp_b_lsu", h_o[1].d_valid, 1); chk("rsp_b_if", h_o[0].d_valid, 0);
    chk("rsp_b_data", h_o[1].d_data, 32'hB);
    tick();
    dev_data = 32'hC; apply(); #1;
    chk("rsp_c_if", h_o[0].d_valid, 1); chk("rsp_c_data", h_o[0].d_data, 32'hC);
    tick();

    // unexpected response
    dev_dv = 1; tick();
    dev_dv = 0; apply(); #1;
    chk("unexp_pulse", err, 1);
    chk("unexp_outst", outst, 0);
    tick();
    apply(); #1;
    chk("unexp_clear", err, 0);

    // reset with outstanding requests
    for (int i = 0; i < 3; i++) begin
      issue(0); tick();
    end
    apply(); #1;
    chk("pre_rst_outst", outst, 3);
    reset_dut();
    issue(0); issue(1); dev_ar = 1;
    peek_grant("post_rst_if", 4'h1);
    tick();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) reset_dut();
      for (int h = 0; h < 2; h++) begin
        if (!hv[h] && $urandom_range(2) != 0) issue(h);
        hdr[h] = ($urandom_range(3) != 0);
      end
      dev_ar   = ($urandom_range(3) != 0);
      dev_dv   = (m_q.size() > 0) ? ($urandom_range(9) < 7) : ($urandom_range(19) == 0);
      dev_data = $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
